uart_rx_fifo: RTL and testbench

- Receive buffer directly downstream of the UART receive FSM.
- Accepts each received byte on a single-cycle valid strobe and returns full_o, which gates the FSM's start-bit acceptance.
- Presents bytes first-word-fall-through to the bus/register side.
- Provides fill level, a level threshold flag, a sticky overrun flag and a character-idle timeout flag for interrupt generation.

---
 rtl/uart_rx_fifo.sv | 122 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer between the UART RX FSM and the bus side.
//
// Ports:
//   clk, rst       system clock, asynchronous active-high reset
//   wr_data_i      received byte, qualified by the one-cycle wr_valid_i strobe
//   full_o         DEPTH entries held; gates start-bit acceptance in the RX FSM
//   rd_en_i        pop request; rd_data_o shows the head entry (first-word-fall-through)
//   empty_o        no entries held
//   count_o        fill level 0..DEPTH
//   level_o        count_o >= THRESH
//   flush_i        synchronous clear of contents, overrun and timeout state
//   ovr_clr_i      clears the sticky overrun_o flag
//   overrun_o      a byte arrived while full with no pop and was dropped
//   timeout_i      idle timeout in clk cycles (0 disables)
//   timeout_o      FIFO non-empty and idle for timeout_i cycles
module uart_rx_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned AW     = $clog2(DEPTH),
  parameter int unsigned THRESH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    wr_data_i,
  input  logic          wr_valid_i,
  output logic          full_o,
  input  logic          rd_en_i,
  output logic [7:0]    rd_data_o,
  output logic          empty_o,
  output logic [AW:0]   count_o,
  output logic          level_o,
  input  logic          flush_i,
  input  logic          ovr_clr_i,
  output logic          overrun_o,
  input  logic [19:0]   timeout_i,
  output logic          timeout_o
);

  localparam logic [AW:0] FullCnt   = (AW+1)'(DEPTH);
  localparam logic [AW:0] ThreshCnt = (AW+1)'(THRESH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overrun_q, overrun_d;
  logic [19:0]   idle_q, idle_d;
  logic          timeout_q, timeout_d;

  logic push, pop, tmo_off;

  // Flags come straight from the count register: no path from wr_valid_i to full_o.
  assign full_o    = (count_q == FullCnt);
  assign empty_o   = (count_q == '0);
  assign level_o   = (count_q >= ThreshCnt);
  assign count_o   = count_q;
  assign overrun_o = overrun_q;
  assign timeout_o = timeout_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so a write at full is accepted alongside it.
  assign pop     = rd_en_i & ~empty_o;
  assign push    = wr_valid_i & (~full_o | pop);
  assign tmo_off = (timeout_i == 20'd0);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    idle_d    = idle_q;
    timeout_d = timeout_q;
    if (flush_i) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      overrun_d = 1'b0;
      idle_d    = '0;
      timeout_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
      // Set wins over clear when both happen in one cycle.
      if (wr_valid_i & full_o & ~pop) overrun_d = 1'b1;
      else if (ovr_clr_i)             overrun_d = 1'b0;
      // Saturates at timeout_i; if timeout_i drops below the count it simply holds,
      // and the equality compare below keeps timeout_o low until the next clear.
      if (push | pop | empty_o | tmo_off) idle_d = '0;
      else if (idle_q < timeout_i)        idle_d = idle_q + 20'd1;
      // Any push/pop drops the flag at the same edge that clears the idle counter.
      timeout_d = (idle_q == timeout_i) & ~tmo_off & ~empty_o & ~(push | pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
    end
  end

  // Storage is deliberately not reset; a flush makes old contents unreachable.
  always_ff @(posedge clk) begin
    if (push & ~flush_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned AW     = 4;
  localparam int unsigned THRESH = 8;

  logic         clk;
  logic         rst;
  logic [7:0]   wr_data_i;
  logic         wr_valid_i;
  logic         full_o;
  logic         rd_en_i;
  logic [7:0]   rd_data_o;
  logic         empty_o;
  logic [AW:0]  count_o;
  logic         level_o;
  logic         flush_i;
  logic         ovr_clr_i;
  logic         overrun_o;
  logic [19:0]  timeout_i;
  logic         timeout_o;

  uart_rx_fifo #(
    .DEPTH  (DEPTH),
    .THRESH (THRESH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_data_i  (wr_data_i),
    .wr_valid_i (wr_valid_i),
    .full_o     (full_o),
    .rd_en_i    (rd_en_i),
    .rd_data_o  (rd_data_o),
    .empty_o    (empty_o),
    .count_o    (count_o),
    .level_o    (level_o),
    .flush_i    (flush_i),
    .ovr_clr_i  (ovr_clr_i),
    .overrun_o  (overrun_o),
    .timeout_i  (timeout_i),
    .timeout_o  (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: FIFO contents as a queue, sticky overrun bit, and the edge
  // index of the last push/pop/flush for the idle timeout.
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  bit         ovr_m;
  longint     n_edge;
  longint     last_act;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_flags();
    bit tmo_exp;
    tmo_exp = (mq.size() > 0) && (timeout_i != 20'd0) &&
              ((n_edge - last_act) > longint'(timeout_i));
    chk("count",   32'(count_o),   32'(mq.size()));
    chk("empty",   32'(empty_o),   32'(mq.size() == 0));
    chk("full",    32'(full_o),    32'(mq.size() == DEPTH));
    chk("level",   32'(level_o),   32'(mq.size() >= THRESH));
    chk("overrun", 32'(overrun_o), 32'(ovr_m));
    chk("timeout", 32'(timeout_o), 32'(tmo_exp));
  endtask

  // One clock cycle of stimulus; called #1 after a rising edge.
  task automatic step(input bit wv, input logic [7:0] wd, input bit re,
                      input bit fl = 1'b0, input bit oc = 1'b0);
    bit pop_m, push_m;
    pop_m  = re && (mq.size() > 0);
    push_m = wv && ((mq.size() < DEPTH) || pop_m);
    wr_valid_i = wv;
    wr_data_i  = wd;
    rd_en_i    = re;
    flush_i    = fl;
    ovr_clr_i  = oc;
    @(posedge clk);
    #1;
    n_edge++;
    if (fl) begin
      mq.delete();
      exp_q.delete();
      ovr_m    = 1'b0;
      last_act = n_edge;
    end else begin
      if (pop_m) void'(mq.pop_front());
      if (push_m) begin
        mq.push_back(wd);
        exp_q.push_back(wd);
      end
      if (wv && !push_m) ovr_m = 1'b1;
      else if (oc)       ovr_m = 1'b0;
      if (push_m || pop_m) last_act = n_edge;
    end
    wr_valid_i = 1'b0;
    rd_en_i    = 1'b0;
    flush_i    = 1'b0;
    ovr_clr_i  = 1'b0;
    chk_flags();
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    ovr_m    = 1'b0;
    last_act = n_edge;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_empty"},   32'(empty_o),   32'd1);
    chk({tag, "_full"},    32'(full_o),    32'd0);
    chk({tag, "_count"},   32'(count_o),   32'd0);
    chk({tag, "_level"},   32'(level_o),   32'd0);
    chk({tag, "_overrun"}, 32'(overrun_o), 32'd0);
    chk({tag, "_timeout"}, 32'(timeout_o), 32'd0);
  endtask

  // Scoreboard monitor: every pop the DUT performs must return the oldest accepted byte.
  always @(negedge clk) begin
    if (!rst && !flush_i && rd_en_i && !empty_o) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rd_data: DUT popped %0h, expected no data (t=%0t)", rd_data_o, $time);
      end else begin
        chk("rd_data", 32'(rd_data_o), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst        = 1'b1;
    wr_data_i  = '0;
    wr_valid_i = 1'b0;
    rd_en_i    = 1'b0;
    flush_i    = 1'b0;
    ovr_clr_i  = 1'b0;
    timeout_i  = 20'd0;
    n_edge     = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst = 1'b0;
    step(0, 8'h00, 0);

    // Three back-to-back writes, then drain.
    step(1, 8'h11, 0);
    step(1, 8'h22, 0);
    step(1, 8'h33, 0);
    chk("head_11", 32'(rd_data_o), 32'h11);
    repeat (3) step(0, 8'h00, 1);

    // Fill, overrun (set beats a same-cycle clear), then clear and drain.
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0);
    step(1, 8'hAA, 0);
    step(1, 8'hAB, 0, 0, 1);
    step(0, 8'h00, 0, 0, 1);
    for (int i = 0; i < 16; i++) step(0, 8'h00, 1);

    // Write and pop together while full.
    for (int i = 0; i < 16; i++) step(1, 8'(8'h40 + i), 0);
    step(1, 8'h55, 1);
    for (int i = 0; i < 16; i++) step(0, 8'h00, 1);
    step(0, 8'h00, 1);

    // Pointer wrap with interleaved write/read pairs.
    for (int i = 0; i < 40; i++) begin
      step(1, 8'(i), 0);
      step(0, 8'h00, 1);
    end

    // Idle timeout.
    timeout_i = 20'd100;
    step(0, 8'h00, 0, 1);
    step(1, 8'hC1, 0);
    step(1, 8'hC2, 0);
    repeat (105) step(0, 8'h00, 0);
    step(0, 8'h00, 1);
    repeat (105) step(0, 8'h00, 0);
    step(0, 8'h00, 1);
    step(0, 8'h00, 0);
    timeout_i = 20'd0;
    step(1, 8'hD0, 0);
    repeat (120) step(0, 8'h00, 0);
    step(0, 8'h00, 1);

    // Flush with five entries and overrun set, with a concurrent write.
    for (int i = 0; i < 17; i++) step(1, 8'(8'h60 + i), 0);
    repeat (11) step(0, 8'h00, 1);
    step(1, 8'h77, 0, 1);
    chk_reset_vals("flush");

    // Randomized traffic with a short timeout.
    timeout_i = 20'd6;
    step(0, 8'h00, 0, 1);
    for (int i = 0; i < 600; i++) begin
      bit wv, re, fl, oc;
      if (i < 300) begin
        wv = ($urandom_range(0, 9) < 7);
        re = ($urandom_range(0, 9) < 2);
      end else begin
        wv = ($urandom_range(0, 9) < 2);
        re = ($urandom_range(0, 9) < 5);
      end
      fl = ($urandom_range(0, 63) == 0);
      oc = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0) begin
        wv = 1'b0;
        re = 1'b0;
      end
      step(wv, 8'($urandom), re, fl, oc);
    end

    // Asynchronous reset in the middle of a burst.
    timeout_i = 20'd0;
    step(0, 8'h00, 0, 1);
    for (int i = 0; i < 17; i++) step(1, 8'(8'h90 + i), 0);
    wr_valid_i = 1'b1;
    wr_data_i  = 8'hEE;
    #3;
    rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    wr_valid_i = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step(0, 8'h00, 0);
    step(1, 8'h3C, 0);
    step(0, 8'h00, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
